// File: rtl/riscv_dmem_arbiter_if.sv
// Bus bundle between the MEM stage / debug loader and the data RAM arbiter.
// The arbiter takes the slave view; requesters and the RAM side take the master view.
interface riscv_dmem_arbiter_if #(
   parameter int ADDR_W = 14
);
   logic              cpu_req;
   logic              cpu_we;
   logic [1:0]        cpu_size;
   logic              cpu_unsigned;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic              cpu_ready;
   logic              cpu_misalign;
   logic [31:0]       cpu_rdata;
   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [31:0]       dbg_wdata;
   logic              dbg_ready;
   logic [31:0]       dbg_rdata;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic [31:0]       ram_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_misalign, cpu_rdata,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ready, dbg_rdata,
      output ram_we, ram_addr, ram_din,
      input  ram_dout
   );

   modport master (
      output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_misalign, cpu_rdata,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ready, dbg_rdata,
      input  ram_we, ram_addr, ram_din,
      output ram_dout
   );
endinterface

// File: rtl/riscv_dmem_arbiter.sv
// Data RAM arbiter: CPU-priority grant with a debug starvation guard, store lane
// steering, load extraction/extension and misalignment detection for the CPU port.
module riscv_dmem_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   riscv_dmem_arbiter_if.slave  bus
);
   localparam int CW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, CPU_ACK, DBG_ACK} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     starve_cnt, starve_nxt;
   logic [ADDR_W-1:0] addr_q, ram_addr_c;
   logic [1:0]        lane_q, size_q;
   logic              uns_q, we_q, mis_q, dbg_we_q;
   logic              gnt_cpu, gnt_dbg, cpu_mis;
   logic [3:0]        ram_we_c;
   logic [31:0]       ram_din_c, cpu_rdata_c, dbg_rdata_c, shifted;
   logic [1:0]        lane;

   assign lane = bus.cpu_addr[1:0];

   // Byte address bits above the RAM window are ignored on purpose.
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.cpu_addr[31:ADDR_W+2];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         addr_q     <= '0;
         lane_q     <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         we_q       <= 1'b0;
         mis_q      <= 1'b0;
         dbg_we_q   <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         addr_q     <= ram_addr_c;
         if (gnt_cpu) begin
            lane_q <= lane;
            size_q <= bus.cpu_size;
            uns_q  <= bus.cpu_unsigned;
            we_q   <= bus.cpu_we;
            mis_q  <= cpu_mis;
         end
         if (gnt_dbg) dbg_we_q <= bus.dbg_we;
      end
   end

   always_comb begin
      state_nxt   = state;
      starve_nxt  = starve_cnt;
      gnt_cpu     = 1'b0;
      gnt_dbg     = 1'b0;
      ram_we_c    = 4'b0000;
      ram_din_c   = '0;
      ram_addr_c  = addr_q;
      cpu_rdata_c = '0;
      dbg_rdata_c = '0;
      shifted     = bus.ram_dout >> {lane_q, 3'b000};
      cpu_mis     = (bus.cpu_size == 2'b11) ||
                    (bus.cpu_size == 2'b01 && lane[0]) ||
                    (bus.cpu_size == 2'b10 && lane != 2'b00);

      // No grant while rst is high, so a reset cycle can never write the RAM.
      case (state)
         IDLE: if (!rst) begin
            if (bus.dbg_req && (!bus.cpu_req || starve_cnt == CW'(STARVE_MAX))) begin
               gnt_dbg   = 1'b1;
               state_nxt = DBG_ACK;
            end else if (bus.cpu_req) begin
               gnt_cpu   = 1'b1;
               state_nxt = CPU_ACK;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (!bus.dbg_req || gnt_dbg)
         starve_nxt = '0;
      else if (gnt_cpu && starve_cnt != CW'(STARVE_MAX))
         starve_nxt = starve_cnt + 1'b1;

      if (gnt_dbg) begin
         ram_addr_c = bus.dbg_addr;
         if (bus.dbg_we) begin
            ram_we_c  = 4'b1111;
            ram_din_c = bus.dbg_wdata;
         end
      end else if (gnt_cpu) begin
         ram_addr_c = bus.cpu_addr[ADDR_W+1:2];
         if (bus.cpu_we && !cpu_mis) begin
            case (bus.cpu_size)
               2'b00: begin
                  ram_we_c  = 4'b0001 << lane;
                  ram_din_c = {4{bus.cpu_wdata[7:0]}};
               end
               2'b01: begin
                  ram_we_c  = lane[1] ? 4'b1100 : 4'b0011;
                  ram_din_c = {2{bus.cpu_wdata[15:0]}};
               end
               default: begin
                  ram_we_c  = 4'b1111;
                  ram_din_c = bus.cpu_wdata;
               end
            endcase
         end
      end

      if (state == CPU_ACK && !we_q && !mis_q) begin
         case (size_q)
            2'b00:   cpu_rdata_c = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   cpu_rdata_c = lane_q[1] ?
                                   {{16{~uns_q & bus.ram_dout[31]}}, bus.ram_dout[31:16]} :
                                   {{16{~uns_q & bus.ram_dout[15]}}, bus.ram_dout[15:0]};
            default: cpu_rdata_c = bus.ram_dout;
         endcase
      end
      if (state == DBG_ACK && !dbg_we_q) dbg_rdata_c = bus.ram_dout;
   end

   assign bus.ram_we       = ram_we_c;
   assign bus.ram_addr     = ram_addr_c;
   assign bus.ram_din      = ram_din_c;
   assign bus.cpu_ready    = (state == CPU_ACK);
   assign bus.cpu_misalign = (state == CPU_ACK) && mis_q;
   assign bus.cpu_rdata    = cpu_rdata_c;
   assign bus.dbg_ready    = (state == DBG_ACK);
   assign bus.dbg_rdata    = dbg_rdata_c;
endmodule
